run_det_sched: RTL and testbench



---
 rtl/run_det_pkg.sv | 34 +++
 rtl/run_det_core.sv | 52 +++++
 rtl/run_det_sched.sv | 140 ++++++++++++++
 tb/tb_run_det_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run_det_sched scheduler and its detector core.
package run_det_pkg;

  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned MAX_CH_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_e;

  // First set request at or after ptr, wrapping modulo nch; 0 when none set.
  function automatic logic [MAX_CH_W-1:0] rr_pick(
    input logic [MAX_CH-1:0]   req,
    input logic [MAX_CH_W-1:0] ptr,
    input int unsigned         nch
  );
    logic [MAX_CH_W-1:0] sel;
    logic                found;
    int unsigned         idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      idx = (32'(ptr) + i) % nch;
      if (!found && (i < nch) && req[idx[MAX_CH_W-1:0]]) begin
        sel   = idx[MAX_CH_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/run_det_core.sv
// Run-of-ones detector: counts runs of RUN_LEN consecutive ones, one hit per run.
module run_det_core #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_vld,
  input  logic             bit_in,
  output logic             hit,
  output logic [CNT_W-1:0] hits
);

  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] HITS_MAX = '1;

  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] hits_q, hits_d;

  // Fires only on the 1 that completes the run; saturated run never re-fires.
  assign hit = !clr && bit_vld && bit_in && (run_q == RUN_W'(RUN_LEN - 1));

  always_comb begin
    run_d  = run_q;
    hits_d = hits_q;
    if (clr) begin
      run_d  = '0;
      hits_d = '0;
    end else if (bit_vld) begin
      if (bit_in) begin
        if (run_q != RUN_W'(RUN_LEN)) run_d = run_q + RUN_W'(1);
      end else begin
        run_d = '0;
      end
      if (hit && (hits_q != HITS_MAX)) hits_d = hits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      hits_q <= '0;
    end else begin
      run_q  <= run_d;
      hits_q <= hits_d;
    end
  end

  assign hits = hits_q;

endmodule

// File: rtl/run_det_sched.sv
// Round-robin scheduler sharing one run_det_core across NCH serial requesters.
// Optional stall timeout enabled by defining RUN_DET_SCHED_TIMEOUT_EN.
module run_det_sched
  import run_det_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH-1:0]          req_bit,
  input  logic [NCH-1:0]          req_last,
  output logic [NCH-1:0]          req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic [CNT_W-1:0]        res_hits,
  output logic                    res_abort,
  output logic                    busy
);

  localparam int unsigned GW = $clog2(NCH);

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            abort_q, abort_d;

  logic            beat;
  logic            cur_bit;
  logic            cur_last;
  logic            stall_expired;
  logic [GW-1:0]   pick_idx;
  logic [CNT_W-1:0] core_hits;
  logic            core_hit_unused;

  // Ready fans out from registered state only, never from req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == STREAM) req_ready[grant_q] = 1'b1;
  end

  assign beat     = |(req_valid & req_ready);
  assign cur_bit  = req_bit[grant_q];
  assign cur_last = req_last[grant_q];
  assign pick_idx = GW'(rr_pick(MAX_CH'(req_valid), MAX_CH_W'(rr_ptr_q), NCH));

`ifdef RUN_DET_SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Counts consecutive beat-less STREAM cycles; zero everywhere else.
  always_comb begin
    stall_d = '0;
    if ((state_q == STREAM) && !beat) stall_d = stall_q + STALL_W'(1);
  end

  assign stall_expired = (state_q == STREAM) && !beat &&
                         (stall_q == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign stall_expired  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick_idx;
          abort_d = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat && cur_last) begin
          state_d = REPORT;
        end else if (stall_expired) begin
          abort_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          rr_ptr_d = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      abort_q  <= abort_d;
    end
  end

  // Core is held clear while idle so every grant starts a fresh burst.
  run_det_core #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == IDLE),
    .bit_vld (beat),
    .bit_in  (cur_bit),
    .hit     (core_hit_unused),
    .hits    (core_hits)
  );

  assign res_valid = (state_q == REPORT);
  assign res_ch    = grant_q;
  assign res_hits  = core_hits;
  assign res_abort = abort_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_run_det_sched.sv
// Directed self-checking bench for run_det_sched (NCH=4, RUN_LEN=3, CNT_W=8, TIMEOUT=16).
module tb_run_det_sched;

  localparam int unsigned NCH     = 4;
  localparam int unsigned RUN_LEN = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_bit;
  logic [NCH-1:0]   req_last;
  logic [NCH-1:0]   req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_ch;
  logic [CNT_W-1:0] res_hits;
  logic             res_abort;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          ch;
    logic [63:0] pat;
    int          len;
    int          hits;
    int          hold;
    logic [3:0]  others;
  } vec_t;

  vec_t vecs[8];

  run_det_sched #(
    .NCH     (NCH),
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_hits  (res_hits),
    .res_abort (res_abort),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, " res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, " res_ch"},    64'(res_ch),    64'd0);
    chk({tag, " res_hits"},  64'(res_hits),  64'd0);
    chk({tag, " res_abort"}, 64'(res_abort), 64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
  endtask

  // Full burst from IDLE: grant, stream pat LSB-first, optional backpressure, handshake.
  task automatic burst(input int ch, input logic [63:0] pat, input int len, input int exp_hits,
                       input int hold, input logic [3:0] others, input string tag);
    logic [3:0] m;
    m     = '0;
    m[ch] = 1'b1;
    req_valid[ch] = 1'b1;
    req_bit[ch]   = pat[0];
    req_last[ch]  = (len == 1);
    tick();
    chk({tag, " grant ready"}, 64'(req_ready), 64'(m));
    chk({tag, " busy stream"}, 64'(busy), 64'd1);
    req_valid = req_valid | others;
    for (int i = 0; i < len; i++) begin
      req_bit[ch]  = pat[i];
      req_last[ch] = (i == len - 1);
      chk($sformatf("%s no early res beat%0d", tag, i), 64'(res_valid), 64'd0);
      tick();
    end
    req_valid[ch] = 1'b0;
    req_last[ch]  = 1'b0;
    req_bit[ch]   = 1'b0;
    chk({tag, " res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, " res_ch"},    64'(res_ch),    64'(ch));
    chk({tag, " res_hits"},  64'(res_hits),  64'(exp_hits));
    chk({tag, " res_abort"}, 64'(res_abort), 64'd0);
    chk({tag, " ready off"}, 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk($sformatf("%s hold%0d res_valid", tag, h), 64'(res_valid), 64'd1);
      chk($sformatf("%s hold%0d res_ch", tag, h),    64'(res_ch),    64'(ch));
      chk($sformatf("%s hold%0d res_hits", tag, h),  64'(res_hits),  64'(exp_hits));
      chk($sformatf("%s hold%0d busy", tag, h),      64'(busy),      64'd1);
      chk($sformatf("%s hold%0d ready", tag, h),     64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = req_valid & ~others;
    chk({tag, " idle busy"},  64'(busy),      64'd0);
    chk({tag, " idle valid"}, 64'(res_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_bit   = '0;
    req_last  = '0;
    res_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{ch: 2, pat: 64'hF7,  len: 8,  hits: 2, hold: 0,  others: 4'b0000};
    vecs[1] = '{ch: 0, pat: 64'h3,   len: 2,  hits: 0, hold: 0,  others: 4'b0000};
    vecs[2] = '{ch: 1, pat: 64'h7,   len: 3,  hits: 1, hold: 0,  others: 4'b0000};
    vecs[3] = '{ch: 3, pat: 64'hEED, len: 12, hits: 2, hold: 10, others: 4'b0011};
    vecs[4] = '{ch: 0, pat: 64'h0,   len: 1,  hits: 0, hold: 0,  others: 4'b0000};
    vecs[5] = '{ch: 1, pat: 64'h3F,  len: 6,  hits: 1, hold: 0,  others: 4'b0000};
    vecs[6] = '{ch: 2, pat: 64'h3BF, len: 10, hits: 2, hold: 0,  others: 4'b0000};
    vecs[7] = '{ch: 0, pat: 64'h3B,  len: 6,  hits: 1, hold: 2,  others: 4'b0100};

    do_reset();
    chk_reset_outputs("por");

    for (int v = 0; v < 8; v++) begin
      burst(vecs[v].ch, vecs[v].pat, vecs[v].len, vecs[v].hits, vecs[v].hold,
            vecs[v].others, $sformatf("vec%0d", v));
    end

    // Arbitration: ch0+ch3 from rr_ptr=0, then ch0/ch1/ch3 after wrap.
    do_reset();
    req_valid[3] = 1'b1;
    burst(0, 64'h1, 1, 0, 0, 4'b0000, "arb r1 ch0");
    burst(3, 64'h1, 1, 0, 0, 4'b0000, "arb r1 ch3");
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    burst(0, 64'h7, 3, 1, 0, 4'b0000, "arb r2 ch0");
    burst(1, 64'h1, 1, 0, 0, 4'b0000, "arb r2 ch1");
    burst(3, 64'h0, 1, 0, 0, 4'b0000, "arb r2 ch3");

    // Hit counter saturation: 300 groups of 1,1,1,0 on ch1.
    req_valid[1] = 1'b1;
    req_bit[1]   = 1'b1;
    tick();
    chk("sat grant ready", 64'(req_ready), 64'h2);
    for (int g = 0; g < 300; g++) begin
      for (int k = 0; k < 4; k++) begin
        req_bit[1]  = (k != 3);
        req_last[1] = (g == 299) && (k == 3);
        tick();
      end
    end
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    chk("sat res_valid", 64'(res_valid), 64'd1);
    chk("sat res_ch",    64'(res_ch),    64'd1);
    chk("sat res_hits",  64'(res_hits),  64'd255);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("sat idle", 64'(busy), 64'd0);

    // Reset in the middle of a ch1 burst that already scored a hit.
    req_valid[1] = 1'b1;
    req_bit[1]   = 1'b1;
    tick();
    chk("midrst grant", 64'(req_ready), 64'h2);
    tick();
    tick();
    tick();
    do_reset();
    chk_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst no result c%0d", c), 64'(res_valid), 64'd0);
    end
    burst(1, 64'h7, 3, 1, 0, 4'b0000, "midrst fresh");

    // Stall on ch0 after 1,1,1 with no last.
    do_reset();
    req_valid[0] = 1'b1;
    req_bit[0]   = 1'b1;
    tick();
    chk("stall grant", 64'(req_ready), 64'h1);
    tick();
    tick();
    tick();
    req_valid[0] = 1'b0;
    req_bit[0]   = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
`ifdef RUN_DET_SCHED_TIMEOUT_EN
    chk("timeout stall cycles", 64'(n),         64'd16);
    chk("timeout res_abort",    64'(res_abort), 64'd1);
    chk("timeout res_hits",     64'(res_hits),  64'd1);
    chk("timeout res_ch",       64'(res_ch),    64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("timeout idle", 64'(busy), 64'd0);
`else
    chk("stall stuck cycles", 64'(n),         64'd100);
    chk("stall busy",         64'(busy),      64'd1);
    chk("stall ready",        64'(req_ready), 64'h1);
    chk("stall res_abort",    64'(res_abort), 64'd0);
    do_reset();
    chk_reset_outputs("stall recover");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
